// File: rtl/booth_div_if.sv
// Operand/result bundle for the sequential signed divider.
// The controller drives through the master modport; the divider takes the slave side.
interface booth_div_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             start;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             dz;

    modport master (
        output x, y, start,
        input  q, r, busy, done, dz
    );

    modport slave (
        input  x, y, start,
        output q, r, busy, done, dz
    );
endinterface

// File: rtl/booth_div.sv
// Sequential signed divider: non-restoring on magnitudes, one quotient bit per clock,
// then a single fix-up cycle applies remainder restore and C-truncating sign correction.
//
//   state | meaning
//   IDLE  | waiting for start; q/r/dz hold the last result
//   CALC  | WIDTH iterations, one quotient bit each, MSB first
//   FIX   | restore remainder, apply signs, register results, pulse done
module booth_div #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    booth_div_if.slave  dv
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   pr_q, pr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] ay_q, ay_d;
    logic             sx_q, sx_d;
    logic             sq_q, sq_d;
    logic             yz_q, yz_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   ay_ext;
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   step;
    logic [WIDTH:0]   rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            a_q     <= '0;
            ay_q    <= '0;
            sx_q    <= 1'b0;
            sq_q    <= 1'b0;
            yz_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            a_q     <= a_d;
            ay_q    <= ay_d;
            sx_q    <= sx_d;
            sq_q    <= sq_d;
            yz_q    <= yz_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    // The dividend register doubles as the quotient: bits shift out into the
    // partial remainder at the top while new quotient bits enter at the bottom.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        a_d     = a_q;
        ay_d    = ay_q;
        sx_d    = sx_q;
        sq_d    = sq_q;
        yz_d    = yz_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        done_d  = 1'b0;

        ay_ext = {1'b0, ay_q};
        sh     = {pr_q[WIDTH-1:0], a_q[WIDTH-1]};
        step   = pr_q[WIDTH] ? (sh + ay_ext) : (sh - ay_ext);
        rem    = pr_q[WIDTH] ? (pr_q + ay_ext) : pr_q;

        unique case (state_q)
            IDLE: begin
                if (dv.start) begin
                    sx_d    = dv.x[WIDTH-1];
                    sq_d    = dv.x[WIDTH-1] ^ dv.y[WIDTH-1];
                    yz_d    = (dv.y == '0);
                    a_d     = dv.x[WIDTH-1] ? -dv.x : dv.x;
                    ay_d    = dv.y[WIDTH-1] ? -dv.y : dv.y;
                    pr_d    = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                pr_d = step;
                a_d  = {a_q[WIDTH-2:0], ~step[WIDTH]};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                // With a zero divisor the remainder naturally ends up as |x|, so r = x falls out.
                q_d     = yz_q ? '1 : (sq_q ? -a_q : a_q);
                r_d     = sx_q ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                dz_d    = yz_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dv.q    = q_q;
    assign dv.r    = r_q;
    assign dv.dz   = dz_q;
    assign dv.done = done_q;
    assign dv.busy = (state_q != IDLE);
endmodule

// File: tb/tb_booth_div.sv
// Scoreboard bench for booth_div: stimulus pushes expected results, a negedge monitor
// pops and compares on every done, also checking latency and busy duration.
module tb_booth_div;
    localparam int W = 16;
    localparam int LAT = W + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth_div_if #(.WIDTH(W)) dv ();

    booth_div #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dv    (dv.slave)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Records the edge on which each start is accepted.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) acc_q.delete();
        else if (dv.start && !dv.busy) acc_q.push_back(cyc);
    end

    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (!rst_n) busy_cnt = 0;
        else if (dv.busy) busy_cnt++;
        chk("busy_done_excl", {31'd0, dv.busy & dv.done}, 32'd0);
        if (dv.done) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_q"}, dv.q, e.q);
                chk({e.name, "_r"}, dv.r, e.r);
                chk({e.name, "_dz"}, dv.dz, e.dz);
                if (acc_q.size() > 0) begin
                    a = acc_q.pop_front();
                    chk({e.name, "_latency"}, cyc - a, LAT);
                end
                chk({e.name, "_busy_cycles"}, busy_cnt, LAT);
            end
            busy_cnt = 0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (dv.busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (dv.busy) begin
            errors++;
            checks++;
            $display("FAIL wait_idle_timeout: got busy=1 expected busy=0 within 100 cycles");
        end
    endtask

    task automatic push(input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz, input string nm);
        exp_t e;
        e.q = eq;
        e.r = er;
        e.dz = edz;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                      input string nm);
        wait_idle();
        dv.x = a;
        dv.y = b;
        dv.start = 1'b1;
        push(eq, er, edz, nm);
        @(posedge clk);
        #1;
        dv.start = 1'b0;
        dv.x = 16'hDEAD;
        dv.y = 16'h0BAD;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rx, ry, eq, er;
        int xi, yi;
        int n;
        dv.start = 1'b0;
        dv.x = '0;
        dv.y = '0;
        #1;
        chk("rst_q", dv.q, 0);
        chk("rst_r", dv.r, 0);
        chk("rst_dz", dv.dz, 0);
        chk("rst_busy", dv.busy, 0);
        chk("rst_done", dv.done, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        op(16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, "p100_p7");
        op(16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, "n100_p7");
        op(16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, "p100_n7");
        op(16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, "n100_n7");
        op(16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, "min_neg1");
        op(16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, "min_p1");
        op(16'h8000, 16'h8000, 16'h0001, 16'h0000, 1'b0, "min_min");
        op(16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 1'b0, "max_min");
        op(16'd5,    16'd9,    16'h0000, 16'h0005, 1'b0, "p5_p9");
        op(16'd0,    16'hFFFD, 16'h0000, 16'h0000, 1'b0, "zero_n3");
        op(16'd1234, 16'd0,    16'hFFFF, 16'h04D2, 1'b1, "div_zero");
        op(16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, "dz_cleared");

        // start pulsed mid-CALC with other operands must be ignored
        op(16'd1000, 16'hFFF3, 16'hFFB4, 16'h000C, 1'b0, "midcalc");
        repeat (5) @(posedge clk);
        #1;
        dv.start = 1'b1;
        dv.x = 16'd7;
        dv.y = 16'd1;
        @(posedge clk);
        #1;
        dv.start = 1'b0;

        // start held high through done: second op accepted in the done cycle
        wait_idle();
        dv.x = 16'd200;
        dv.y = 16'd3;
        dv.start = 1'b1;
        push(16'h0042, 16'h0002, 1'b0, "held_a");
        @(posedge clk);
        #1;
        dv.x = 16'hFF38;
        dv.y = 16'd3;
        push(16'hFFBE, 16'hFFFE, 1'b0, "held_b");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dv.done && n < 40);
        chk("held_done_seen", dv.done, 1);
        @(posedge clk);
        #1;
        dv.start = 1'b0;
        chk("held_accept", dv.busy, 1);

        // reset mid-operation discards the op with no done
        op(16'd100, 16'd7, 16'h000E, 16'h0002, 1'b0, "rst_victim");
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_q", dv.q, 0);
        chk("midrst_r", dv.r, 0);
        chk("midrst_dz", dv.dz, 0);
        chk("midrst_busy", dv.busy, 0);
        chk("midrst_done", dv.done, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        op(16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0, "after_rst");

        for (int i = 0; i < 200; i++) begin
            rx = W'($urandom);
            ry = (i % 4 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            if (i % 8 == 4) ry = -ry;
            if (ry == '0) begin
                eq = '1;
                er = rx;
            end else begin
                xi = $signed(rx);
                yi = $signed(ry);
                eq = W'(xi / yi);
                er = W'(xi % yi);
            end
            op(rx, ry, eq, er, (ry == '0), "rand");
        end

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
